delay_line_var: RTL and testbench



---
 rtl/delay_line_var.sv | 97 +++++++++
 tb/tb_delay_line_var.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/delay_line_var.sv
// Multi-channel delay line, programmable at runtime, that advances on en strobes.
// A delay change or a flush clears the pipe, and valid output is held off until the pipe has refilled.
module delay_line_var #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 1,
    parameter int MAX_DEL  = 16,
    parameter int DEL_W    = 5,
    parameter int RST_DEL  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      flush,
    input  logic [DEL_W-1:0]          del_sel,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      din_valid,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic                      dout_valid,
    output logic [DEL_W-1:0]          del_active,
    output logic                      busy
);
    localparam int DW = CHANNELS * WIDTH;

    typedef enum logic {RUN, FILL} state_t;

    state_t             r_state, w_state_nxt;
    logic [DEL_W-1:0]   r_fill_cnt, w_fill_nxt;
    logic [DEL_W-1:0]   r_del;
    logic [DEL_W-1:0]   w_ds;
    logic               w_clear;
    logic [DW-1:0]      r_data [MAX_DEL];
    logic [MAX_DEL-1:0] r_vld;
    logic [DW-1:0]      w_tap_data;
    logic               w_tap_vld;

    assign w_ds    = (del_sel > DEL_W'(MAX_DEL)) ? DEL_W'(MAX_DEL) : del_sel;
    assign w_clear = flush | (w_ds != r_del);

    // On a clear, the incoming word is dropped so that data is never duplicated across a change.
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            for (int unsigned i = 0; i < MAX_DEL; i++) r_data[i] <= '0;
            r_vld <= '0;
        end else if (en) begin
            r_data[0] <= din;
            r_vld[0]  <= din_valid;
            for (int unsigned i = 1; i < MAX_DEL; i++) begin
                r_data[i] <= r_data[i-1];
                r_vld[i]  <= r_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)          r_del <= DEL_W'(RST_DEL);
        else if (w_clear) r_del <= w_ds;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= (RST_DEL == 0) ? RUN : FILL;
            r_fill_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_fill_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill_cnt;
        if (w_clear) begin
            w_state_nxt = (w_ds == '0) ? RUN : FILL;
            w_fill_nxt  = '0;
        end else if (en && r_state == FILL) begin
            if (r_fill_cnt == r_del - DEL_W'(1)) w_state_nxt = RUN;
            else                                 w_fill_nxt  = r_fill_cnt + DEL_W'(1);
        end
    end

    always_comb begin
        w_tap_data = '0;
        w_tap_vld  = 1'b0;
        for (int unsigned i = 0; i < MAX_DEL; i++) begin
            if (r_del == DEL_W'(i + 1)) begin
                w_tap_data = r_data[i];
                w_tap_vld  = r_vld[i];
            end
        end
    end

    assign dout       = (r_del == '0) ? din : w_tap_data;
    assign dout_valid = ((r_del == '0) ? din_valid : w_tap_vld) & (r_state == RUN);
    assign del_active = r_del;
    assign busy       = (r_state == FILL);

endmodule

// File: tb/tb_delay_line_var.sv
// Testbench for delay_line_var: a table of directed vectors, directed corner sequences, and random stimulus.
// All results are checked against a queue-based model of the delay line.
module tb_delay_line_var;
    localparam int WIDTH = 8, CHANNELS = 2, MAX_DEL = 16, DEL_W = 5, RST_DEL = 1;
    localparam int DW = WIDTH * CHANNELS;

    logic             clk = 1'b0;
    logic             rst = 1'b0, en = 1'b0, flush = 1'b0, din_valid = 1'b0;
    logic [DEL_W-1:0] del_sel = 5'd1;
    logic [DW-1:0]    din = '0;
    logic [DW-1:0]    dout;
    logic             dout_valid, busy;
    logic [DEL_W-1:0] del_active;

    delay_line_var #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_DEL(MAX_DEL),
                     .DEL_W(DEL_W), .RST_DEL(RST_DEL)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .del_sel(del_sel),
        .din(din), .din_valid(din_valid), .dout(dout), .dout_valid(dout_valid),
        .del_active(del_active), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: history of accepted words since the last clear, newest first.
    typedef struct packed { logic v; logic [DW-1:0] d; } ent_t;
    ent_t        m_hist[$];
    int unsigned m_cnt = 0;
    int unsigned m_del = RST_DEL;
    bit          m_on  = 1'b0;

    logic [DW-1:0]    s_dout;
    logic             s_vld, s_busy;
    logic [DEL_W-1:0] s_del;

    task automatic tick(input logic r, input logic e, input logic f, input logic [DEL_W-1:0] s,
                        input logic [DW-1:0] d, input logic v);
        logic [DW-1:0] ed;
        logic          ev, eb;
        int unsigned   ds;
        rst = r; en = e; flush = f; del_sel = s; din = d; din_valid = v;
        #2;
        s_dout = dout; s_vld = dout_valid; s_busy = busy; s_del = del_active;
        if (m_del == 0) begin
            ed = d; ev = v; eb = 1'b0;
        end else if (m_cnt >= m_del) begin
            ed = m_hist[m_del-1].d; ev = m_hist[m_del-1].v; eb = 1'b0;
        end else begin
            ed = '0; ev = 1'b0; eb = 1'b1;
        end
        if (m_on) begin
            chk("model_dout",  32'(s_dout), 32'(ed));
            chk("model_valid", 32'(s_vld),  32'(ev));
            chk("model_busy",  32'(s_busy), 32'(eb));
            chk("model_del",   32'(s_del),  32'(m_del));
        end
        @(posedge clk);
        ds = (int'(s) > MAX_DEL) ? MAX_DEL : int'(s);
        if (r) begin
            m_hist.delete(); m_cnt = 0; m_del = RST_DEL; m_on = 1'b1;
        end else if (f || ds != m_del) begin
            m_hist.delete(); m_cnt = 0; m_del = ds;
        end else if (e) begin
            m_hist.push_front('{v: v, d: d});
            if (m_hist.size() > MAX_DEL) void'(m_hist.pop_back());
            if (m_cnt < MAX_DEL) m_cnt++;
        end
        #1;
    endtask

    typedef struct {
        logic en, flush; logic [DEL_W-1:0] sel; logic [DW-1:0] din; logic vld;
        logic [DW-1:0] e_dout; logic e_vld, e_busy; logic [DEL_W-1:0] e_del;
    } vec_t;
    vec_t tbl[14];

    initial begin
        int unsigned k;
        int unsigned lat;
        logic [DEL_W-1:0] rs;

        tbl[0]  = '{1, 0, 1, 16'h0101, 1, 16'h0000, 0, 1, 1};
        tbl[1]  = '{1, 0, 1, 16'h0202, 1, 16'h0101, 1, 0, 1};
        tbl[2]  = '{1, 0, 1, 16'h0303, 0, 16'h0202, 1, 0, 1};
        tbl[3]  = '{0, 0, 1, 16'h0404, 1, 16'h0303, 0, 0, 1};
        tbl[4]  = '{1, 0, 1, 16'h0404, 1, 16'h0303, 0, 0, 1};
        tbl[5]  = '{1, 0, 0, 16'h0505, 1, 16'h0404, 1, 0, 1};
        tbl[6]  = '{1, 0, 0, 16'h0606, 0, 16'h0606, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 16'h0707, 1, 16'h0707, 1, 0, 0};
        tbl[8]  = '{1, 0, 3, 16'h0808, 1, 16'h0808, 1, 0, 0};
        tbl[9]  = '{1, 0, 3, 16'h0909, 1, 16'h0000, 0, 1, 3};
        tbl[10] = '{1, 0, 3, 16'h0a0a, 1, 16'h0000, 0, 1, 3};
        tbl[11] = '{1, 0, 3, 16'h0b0b, 1, 16'h0000, 0, 1, 3};
        tbl[12] = '{1, 1, 3, 16'h0c0c, 1, 16'h0909, 1, 0, 3};
        tbl[13] = '{1, 0, 3, 16'h0d0d, 1, 16'h0000, 0, 1, 3};

        @(posedge clk); #1;
        tick(1, 0, 0, 1, '0, 0);
        tick(1, 0, 0, 1, '0, 0);

        for (int i = 0; i < 14; i++) begin
            tick(0, tbl[i].en, tbl[i].flush, tbl[i].sel, tbl[i].din, tbl[i].vld);
            chk($sformatf("tbl%0d_dout", i),  32'(s_dout), 32'(tbl[i].e_dout));
            chk($sformatf("tbl%0d_valid", i), 32'(s_vld),  32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_busy", i),  32'(s_busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_del", i),   32'(s_del),  32'(tbl[i].e_del));
        end

        // Saturating select: 31 gives 16 stages, and a marker emerges after exactly 16 strobes.
        tick(0, 1, 0, 31, 16'h1111, 1);
        tick(0, 1, 0, 31, 16'hbeef, 1);
        chk("sat_del", 32'(s_del), 32'd16);
        k = 1; lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick(0, (i % 3) != 1, 0, 31, 16'(i), 0);
            if (s_vld && s_dout == 16'hbeef) begin lat = k; break; end
            if ((i % 3) != 1) k++;
        end
        chk("sat_latency_strobes", lat, 32'd16);

        // Bypass: the output follows the input combinationally within the same cycle.
        tick(0, 1, 0, 0, 16'h2222, 1);
        tick(0, 0, 0, 0, 16'h5a5a, 1);
        chk("bypass_dout", 32'(s_dout), 32'h5a5a);
        chk("bypass_busy", 32'(s_busy), 32'd0);

        // Reset during fill restores RST_DEL, then the change path loads the held select.
        tick(0, 1, 0, 5, 16'h0001, 1);
        tick(0, 1, 0, 5, 16'h0002, 1);
        tick(1, 1, 0, 5, 16'h0003, 1);
        tick(0, 1, 0, 5, 16'h0004, 1);
        chk("rst_del_restored", 32'(s_del), 32'd1);
        chk("rst_dout_zero", 32'(s_dout), 32'd0);
        tick(0, 1, 0, 5, 16'h0005, 1);
        chk("rst_del_changed", 32'(s_del), 32'd5);
        chk("rst_busy", 32'(s_busy), 32'd1);

        rs = 5'd4;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 3) rs = 5'($urandom_range(31));
            tick($urandom_range(199) == 0, $urandom_range(9) < 7, $urandom_range(99) < 2,
                 rs, 16'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
